// File: rtl/add_share_arb.sv
// Round-robin sequencer that time-shares one external WIDTH-bit adder among NREQ requesters.
// Latency: grant at edge G, captured sum and done at edge G+SETTLE; one operation per SETTLE+1 cycles.
// Backpressure: requesters hold req/operands until gnt; req is ignored while busy, losers simply wait.
module add_share_arb #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int WIDTH  = 4,
  parameter int SETTLE = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH:0]        add_sum,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH:0]        result
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] win_oh;
  logic            found;
  logic            load;
  logic            capture;

  // Round-robin search: first requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    win_oh[win] = found;
  end

  // Pointer advances to the requester just after the one that completed.
  always_comb begin
    ptr_nxt = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
  end

  // Next-state logic: grant from IDLE, capture when the settle countdown expires.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand, countdown and result registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      add_a   <= '0;
      add_b   <= '0;
      cnt     <= '0;
      owner   <= '0;
      ptr     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      result  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      done  <= 1'b0;
      if (load) begin
        gnt   <= win_oh;
        add_a <= req_a[int'(win)*WIDTH +: WIDTH];
        add_b <= req_b[int'(win)*WIDTH +: WIDTH];
        cnt   <= 4'(SETTLE - 1);
        owner <= win;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        result  <= add_sum;
        done    <= 1'b1;
        done_id <= owner;
        ptr     <= ptr_nxt;
      end
    end
  end

  assign busy = (state == WAIT);

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed scenarios plus randomized traffic against a transaction-level model.
// The shared adder is modelled as a plain combinational sum of the registered operands.
// Every wait on the DUT is bounded; the run always reaches the summary line.
module tb_add_share_arb;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int WIDTH  = 4;
  localparam int SETTLE = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH:0]        add_sum;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [WIDTH:0]        result;

  int opa [NREQ];
  int opb [NREQ];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mptr     = 0;
  int g_cyc    = 0;
  int g_prev   = 0;

  add_share_arb #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .busy(busy), .done(done),
    .done_id(done_id), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pack the per-requester operand arrays onto the flat buses.
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(opa[i]);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(opb[i]);
    end
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int winner(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (gnt != '0) got = 1'b1;
    end
    check("gnt_seen", {31'b0, got}, 32'd1);
  endtask

  // One full operation for requester w; keep leaves req high after grant, wd injects a withdrawn req3.
  task automatic do_op(input int w, input bit keep, input bit wd);
    bit got;
    int ea;
    int eb;
    ea = opa[w];
    eb = opb[w];
    wait_gnt(got);
    g_prev = g_cyc;
    g_cyc  = cyc;
    check("gnt_onehot", gnt, 32'(1 << w));
    check("add_a_load", add_a, ea);
    check("add_b_load", add_b, eb);
    check("busy_at_g", busy, 1);
    check("done_at_g", done, 0);
    if (!keep) req[w] = 1'b0;
    for (int k = 1; k < SETTLE; k++) begin
      if (wd && k == 1) begin
        opa[3] = 7; opb[3] = 9; req[3] = 1'b1;
      end
      if (wd && k == SETTLE - 2) req[3] = 1'b0;
      tick();
      check("busy_wait", busy, 1);
      check("done_wait", done, 0);
      check("gnt_wait", gnt, 0);
      check("add_a_hold", add_a, ea);
    end
    tick();
    check("done_pulse", done, 1);
    check("done_id", done_id, w);
    check("result", result, ea + eb);
    check("busy_end", busy, 0);
    check("gnt_at_done", gnt, 0);
    mptr = (w + 1) % NREQ;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst  = 1'b0;
    mptr = 0;
  endtask

  initial begin
    int exp_order [5];
    int w;
    bit got;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin opa[i] = 0; opb[i] = 0; end
    rst = 1'b1;
    req = '0;
    #3;
    check("rst_gnt", gnt, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_result", result, 0);
    do_reset();

    // Single requester, no carry.
    opa[0] = 'hA; opb[0] = 'h3; req[0] = 1'b1;
    do_op(0, 0, 0);

    // Carry out of the top bit, twice on requester 2.
    opa[2] = 'hF; opb[2] = 'hF; req[2] = 1'b1;
    do_op(2, 0, 0);
    check("carry_res_1e", result, 'h1E);
    opa[2] = 'hF; opb[2] = 'h1; req[2] = 1'b1;
    do_op(2, 0, 0);
    check("carry_res_10", result, 'h10);

    // Full contention from reset: strict rotation, SETTLE+1 cycles apart.
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = $urandom_range(0, 15); opb[i] = $urandom_range(0, 15);
    end
    req = '1;
    tick();
    rst  = 1'b0;
    mptr = 0;
    for (int i = 0; i < 5; i++) begin
      w = winner(req, mptr);
      check("rr_model_order", w, exp_order[i]);
      do_op(w, 1, 0);
      if (i > 0) check("grant_spacing", g_cyc - g_prev, SETTLE + 1);
    end
    req = '0;

    // Fairness: bring ptr to 2, then req1 and req3 contend.
    do_reset();
    opa[1] = 4; opb[1] = 5; req[1] = 1'b1;
    do_op(1, 0, 0);
    opa[3] = 'hC; opb[3] = 'h6;
    req = 4'b1010;
    do_op(3, 1, 0);
    do_op(1, 1, 0);
    do_op(3, 1, 0);
    req = '0;

    // Asynchronous reset two cycles into an operation.
    do_reset();
    opa[0] = 'h2; opb[0] = 'h8; req[0] = 1'b1;
    wait_gnt(got);
    check("rstmid_gnt", gnt, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rstmid_gnt0", gnt, 0);
    check("rstmid_add_a", add_a, 0);
    check("rstmid_add_b", add_b, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_result", result, 0);
    tick();
    opa[1] = 'h3; opb[1] = 'h4;
    req  = 4'b0011;
    rst  = 1'b0;
    mptr = 0;
    do_op(0, 0, 0);
    do_op(1, 0, 0);

    // Withdrawal: req3 pulses during WAIT and must never be granted.
    opa[0] = 'h5; opb[0] = 'h6; req[0] = 1'b1;
    do_op(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wd_no_gnt", gnt, 0);
      check("wd_idle", busy, 0);
    end

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 30; it++) begin
      if (req == '0) begin
        w = $urandom_range(0, NREQ - 1);
        opa[w] = $urandom_range(0, 15); opb[w] = $urandom_range(0, 15);
        req[w] = 1'b1;
      end
      w = winner(req, mptr);
      do_op(w, 0, 0);
      for (int j = 0; j < NREQ; j++) begin
        if (!req[j] && $urandom_range(0, 1) == 1) begin
          opa[j] = $urandom_range(0, 15); opb[j] = $urandom_range(0, 15);
          req[j] = 1'b1;
        end
      end
    end
    req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
